conv2d_event_accumulator: RTL and testbench
===========================================

CONV2D_EVENT_ACCUMULATOR -- requirements
Module: conv2d_event_accumulator

Interface
REQ-001 IN_CHANNELS, 2, input spike channels per event.
REQ-002 OUT_CHANNELS, 2, output feature-map channels.
REQ-003 KERNEL_SIZE, 3, odd kernel side K; R = K/2.
REQ-004 KERNEL_WEIGHT_BITS, 6, signed weight width W.
REQ-005 BITS_PER_CHANNEL, 6, signed membrane-potential width B.
REQ-006 COORD_BITS, 8, event coordinate width.
REQ-007 IMG_WIDTH, 8, feature-map width; IMG_HEIGHT, 8, feature-map height; AW = clog2(IMG_WIDTH*IMG_HEIGHT).
REQ-008 clk  in  1  single clock, all logic on rising edge.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 event_valid  in  1  event offered.
REQ-011 event_ready  out  1  event accepted when valid&ready.
REQ-012 event_x / event_y  in  COORD_BITS each  event pixel.
REQ-013 event_spikes  in  IN_CHANNELS  per-channel spike bits.
REQ-014 kern_rd_en  out  1  kernel read strobe.
REQ-015 kern_addr  out  clog2(IN_CHANNELS*K*K)  = ic*K*K + ky*K + kx.
REQ-016 kern_data  in  OUT_CHANNELS*W  weights, valid one cycle after kern_rd_en; channel oc at bits [oc*W +: W].
REQ-017 mem_rd_en  out  1; mem_rd_addr  out  AW  = y*IMG_WIDTH + x.
REQ-018 mem_rd_valid  in  1; mem_rd_data  in  OUT_CHANNELS*B  potentials, same packing.
REQ-019 mem_wr_en  out  1; mem_wr_addr  out  AW; mem_wr_data  out  OUT_CHANNELS*B; mem_wr_ready  in  1.
REQ-020 busy  out  1  FSM not IDLE; event_done  out  1  one-cycle pulse at event completion; sat_flag  out  1  sticky saturation.

Function
REQ-021 FSM states IDLE, NEXT, READ, WAIT_RD, WRITE, DONE; event_ready = 1 only in IDLE.
REQ-022 Accept in IDLE: latch x, y, spikes; clear sat_flag; go NEXT with ic=0, ky=0, kx=0.
REQ-023 Traversal order: ic outer, ky, kx inner; channels with spike bit 0 skipped entirely.
REQ-024 Tap target: tx = x + kx - R, ty = y + ky - R (signed, COORD_BITS+1); tap outside [0,IMG_WIDTH-1]x[0,IMG_HEIGHT-1] skipped, no memory or kernel access, one cycle in NEXT per skipped tap.
REQ-025 NEXT with valid tap -> READ: assert kern_rd_en one cycle and mem_rd_en; mem_rd_en/mem_rd_addr held stable through WAIT_RD until mem_rd_valid; kern_data captured the cycle after kern_rd_en.
REQ-026 On mem_rd_valid: per channel new = sat(pot + sign-extended weight), clamp to [-2^(B-1), 2^(B-1)-1]; any clamp sets sat_flag; -> WRITE.
REQ-027 WRITE: mem_wr_en, addr, data held stable until mem_wr_ready sampled high; then NEXT with next tap.
REQ-028 After last tap of last channel -> DONE: event_done=1 one cycle -> IDLE; event with zero spikes reaches DONE directly, no memory access.
REQ-029 Never more than one outstanding read or write; mem_rd_en and mem_wr_en never both high.

Reset
REQ-030 rst_n low, asynchronously, including mid-event: FSM IDLE, all outputs 0 except event_ready=1, sat_flag=0, in-flight event discarded, partial writes not reissued.

Verification (IN=2, OUT=2, K=3, W=B=6, 8x8, all weights +1, memory zero unless stated)
REQ-031 Reset held 5 cycles -> outputs 0, event_ready=1, busy=0; release -> no strobes.
REQ-032 Event (5,3) spikes 2'b11 -> 18 read/write pairs over x 4..6, y 2..4; each pixel ends at 2 in both channels; one event_done.
REQ-033 Event (0,0) spikes 2'b01 -> 4 accesses (addr 0,1,8,9) only, each ends at 1; no wrapped addresses.
REQ-034 Potential 30, weight +5 -> writes 31, sat_flag=1; potential -30, weight -5 -> writes -32.
REQ-035 mem_rd_valid delayed 3 cycles, mem_wr_ready low 2 cycles -> addresses/data held stable, final memory identical to REQ-032.
REQ-036 Spikes 2'b00 -> event_done 2 cycles after accept, no strobes; rst_n pulsed after 5th write of REQ-032 event -> IDLE immediately, no further writes.

Source files
------------

// File: rtl/conv2d_event_accumulator.sv
// ---------------------------------------------------------------------------
// conv2d_event_accumulator
//
// Event-driven 2-D convolution accumulator for a spiking feature map.
// Each accepted event (x, y, spike bits) scatters one KxK kernel per spiking
// input channel onto the membrane potentials around (x, y). Each in-bounds tap
// reads the kernel weights and the potentials of the target pixel. It adds
// them with saturation and writes the result back. At most one memory
// transaction is outstanding at any time.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   event_valid / event_ready     event handshake (ready only while idle)
//   event_x, event_y              event pixel coordinates
//   event_spikes                  one spike bit per input channel
//   kern_rd_en, kern_addr         kernel read strobe and address
//   kern_data                     weights, valid the cycle after kern_rd_en
//   mem_rd_en, mem_rd_addr        potential read request (held until valid)
//   mem_rd_valid, mem_rd_data     potential read response
//   mem_wr_en, mem_wr_addr,       potential write request
//   mem_wr_data, mem_wr_ready     (held until ready is sampled high)
//   busy                          an event is in progress
//   event_done                    one-cycle pulse when an event completes
//   sat_flag                      sticky: a write of this event clamped
// ---------------------------------------------------------------------------
module conv2d_event_accumulator #(
    parameter int IN_CHANNELS        = 2,
    parameter int OUT_CHANNELS       = 2,
    parameter int KERNEL_SIZE        = 3,
    parameter int KERNEL_WEIGHT_BITS = 6,
    parameter int BITS_PER_CHANNEL   = 6,
    parameter int COORD_BITS         = 8,
    parameter int IMG_WIDTH          = 8,
    parameter int IMG_HEIGHT         = 8,
    localparam int AW  = $clog2(IMG_WIDTH * IMG_HEIGHT),
    localparam int KAW = $clog2(IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       event_valid,
    output logic                                       event_ready,
    input  logic [COORD_BITS-1:0]                      event_x,
    input  logic [COORD_BITS-1:0]                      event_y,
    input  logic [IN_CHANNELS-1:0]                     event_spikes,
    output logic                                       kern_rd_en,
    output logic [KAW-1:0]                             kern_addr,
    input  logic [OUT_CHANNELS*KERNEL_WEIGHT_BITS-1:0] kern_data,
    output logic                                       mem_rd_en,
    output logic [AW-1:0]                              mem_rd_addr,
    input  logic                                       mem_rd_valid,
    input  logic [OUT_CHANNELS*BITS_PER_CHANNEL-1:0]   mem_rd_data,
    output logic                                       mem_wr_en,
    output logic [AW-1:0]                              mem_wr_addr,
    output logic [OUT_CHANNELS*BITS_PER_CHANNEL-1:0]   mem_wr_data,
    input  logic                                       mem_wr_ready,
    output logic                                       busy,
    output logic                                       event_done,
    output logic                                       sat_flag
);

    localparam int R   = KERNEL_SIZE / 2;
    localparam int CW  = COORD_BITS + 2;   // signed tap coordinate, no overflow at the far edge
    localparam int KCW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int ICW = $clog2(IN_CHANNELS + 1);
    localparam int WB  = KERNEL_WEIGHT_BITS;
    localparam int B   = BITS_PER_CHANNEL;
    localparam int SW  = ((B > WB) ? B : WB) + 1;

    localparam logic signed [CW-1:0] IMG_W_S = CW'(IMG_WIDTH);
    localparam logic signed [CW-1:0] IMG_H_S = CW'(IMG_HEIGHT);
    localparam logic signed [SW-1:0] POT_MAX = SW'(2 ** (B - 1) - 1);
    localparam logic signed [SW-1:0] POT_MIN = SW'(-(2 ** (B - 1)));
    localparam logic [ICW-1:0]       IC_END  = ICW'(IN_CHANNELS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_NEXT    = 3'd1;
    localparam logic [2:0] S_READ    = 3'd2;
    localparam logic [2:0] S_WAIT_RD = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]                           state;
    logic [COORD_BITS-1:0]                x_q, y_q;
    logic [IN_CHANNELS-1:0]               spikes_q;
    logic [ICW-1:0]                       ic_q;
    logic [KCW-1:0]                       ky_q, kx_q;
    logic [AW-1:0]                        addr_q;
    logic [KAW-1:0]                       kern_addr_q;
    logic                                 kern_pending_q;
    logic [OUT_CHANNELS*WB-1:0]           weight_q;
    logic [OUT_CHANNELS*B-1:0]            wr_data_q;
    logic                                 sat_q;

    logic signed [CW-1:0]                 tx, ty;
    logic                                 tap_valid;
    logic [AW-1:0]                        tap_addr;
    logic [KAW-1:0]                       tap_kaddr;
    logic [KCW-1:0]                       adv_kx, adv_ky;
    logic [ICW-1:0]                       adv_ic;
    logic [OUT_CHANNELS*WB-1:0]           weights_eff;
    logic [OUT_CHANNELS*B-1:0]            new_data;
    logic                                 any_sat;

    // Lowest spiking channel at or above 'from'; IN_CHANNELS when none is left.
    // Silent channels are thereby skipped without spending any cycles.
    function automatic logic [ICW-1:0] next_channel(input logic [IN_CHANNELS-1:0] sp,
                                                    input int from);
        logic [ICW-1:0] res;
        res = IC_END;
        for (int i = IN_CHANNELS - 1; i >= 0; i--) begin
            if (i >= from && sp[i]) res = ICW'(i);
        end
        return res;
    endfunction

    // Tap target relative to the event pixel, checked against the map bounds.
    assign tx = $signed({2'b00, x_q}) + $signed(CW'(kx_q)) - $signed(CW'(R));
    assign ty = $signed({2'b00, y_q}) + $signed(CW'(ky_q)) - $signed(CW'(R));
    assign tap_valid = !tx[CW-1] && (tx < IMG_W_S) && !ty[CW-1] && (ty < IMG_H_S);
    assign tap_addr  = AW'(int'(ty) * IMG_WIDTH + int'(tx));
    assign tap_kaddr = KAW'(int'(ic_q) * KERNEL_SIZE * KERNEL_SIZE
                            + int'(ky_q) * KERNEL_SIZE + int'(kx_q));

    // Step to the following tap: kx fastest, then ky, then the next spiking channel.
    // NOTE: every signal written in an always_comb gets a default at the top so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        adv_kx = kx_q + 1'b1;
        adv_ky = ky_q;
        adv_ic = ic_q;
        if (kx_q == KCW'(KERNEL_SIZE - 1)) begin
            adv_kx = '0;
            adv_ky = ky_q + 1'b1;
            if (ky_q == KCW'(KERNEL_SIZE - 1)) begin
                adv_ky = '0;
                adv_ic = next_channel(spikes_q, int'(ic_q) + 1);
            end
        end
    end

    // Weights arrive in the first WAIT_RD cycle; use them directly then,
    // afterwards the captured copy (the kernel bus is not held).
    assign weights_eff = kern_pending_q ? kern_data : weight_q;

    always_comb begin
        new_data = '0;
        any_sat  = 1'b0;
        for (int oc = 0; oc < OUT_CHANNELS; oc++) begin
            logic signed [B-1:0]  pot;
            logic signed [WB-1:0] w;
            logic signed [SW-1:0] sum;
            pot = mem_rd_data[oc*B +: B];
            w   = weights_eff[oc*WB +: WB];
            sum = SW'(pot) + SW'(w);
            if (sum > POT_MAX) begin
                sum     = POT_MAX;
                any_sat = 1'b1;
            end else if (sum < POT_MIN) begin
                sum     = POT_MIN;
                any_sat = 1'b1;
            end
            new_data[oc*B +: B] = sum[B-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            x_q            <= '0;
            y_q            <= '0;
            spikes_q       <= '0;
            ic_q           <= '0;
            ky_q           <= '0;
            kx_q           <= '0;
            addr_q         <= '0;
            kern_addr_q    <= '0;
            kern_pending_q <= 1'b0;
            weight_q       <= '0;
            wr_data_q      <= '0;
            sat_q          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (event_valid) begin
                        x_q      <= event_x;
                        y_q      <= event_y;
                        spikes_q <= event_spikes;
                        sat_q    <= 1'b0;
                        ic_q     <= next_channel(event_spikes, 0);
                        ky_q     <= '0;
                        kx_q     <= '0;
                        state    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (ic_q == IC_END) begin
                        state <= S_DONE;
                    end else if (tap_valid) begin
                        addr_q         <= tap_addr;
                        kern_addr_q    <= tap_kaddr;
                        kern_pending_q <= 1'b1;
                        state          <= S_READ;
                    end else begin
                        kx_q <= adv_kx;
                        ky_q <= adv_ky;
                        ic_q <= adv_ic;
                    end
                end
                S_READ: state <= S_WAIT_RD;
                S_WAIT_RD: begin
                    if (kern_pending_q) begin
                        weight_q       <= kern_data;
                        kern_pending_q <= 1'b0;
                    end
                    if (mem_rd_valid) begin
                        wr_data_q <= new_data;
                        if (any_sat) sat_q <= 1'b1;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (mem_wr_ready) begin
                        kx_q  <= adv_kx;
                        ky_q  <= adv_ky;
                        ic_q  <= adv_ic;
                        state <= S_NEXT;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign event_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign kern_rd_en  = (state == S_READ);
    assign kern_addr   = kern_addr_q;
    assign mem_rd_en   = (state == S_READ) || (state == S_WAIT_RD);
    assign mem_rd_addr = addr_q;
    assign mem_wr_en   = (state == S_WRITE);
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = wr_data_q;
    assign event_done  = (state == S_DONE);
    assign sat_flag    = sat_q;

endmodule

// File: tb/tb_conv2d_event_accumulator.sv
// ---------------------------------------------------------------------------
// tb_conv2d_event_accumulator
//
// Directed bench for conv2d_event_accumulator (2 in / 2 out channels, 3x3
// kernel, 6-bit weights and potentials, 8x8 map). A behavioural kernel ROM and
// potential memory answer the DUT with programmable read/write latency and
// watch the handshake rules. Scenario tasks compare against hand-derived values.
// ---------------------------------------------------------------------------
module tb_conv2d_event_accumulator;

    localparam int IN  = 2;
    localparam int OUT = 2;
    localparam int K   = 3;
    localparam int W   = 6;
    localparam int B   = 6;
    localparam int CB  = 8;
    localparam int AW  = 6;
    localparam int KAW = 5;
    localparam int NPIX = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              event_valid = 1'b0;
    logic              event_ready;
    logic [CB-1:0]     event_x = '0;
    logic [CB-1:0]     event_y = '0;
    logic [IN-1:0]     event_spikes = '0;
    logic              kern_rd_en;
    logic [KAW-1:0]    kern_addr;
    logic [OUT*W-1:0]  kern_data = '0;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_rd_addr;
    logic              mem_rd_valid = 1'b0;
    logic [OUT*B-1:0]  mem_rd_data = '0;
    logic              mem_wr_en;
    logic [AW-1:0]     mem_wr_addr;
    logic [OUT*B-1:0]  mem_wr_data;
    logic              mem_wr_ready = 1'b0;
    logic              busy;
    logic              event_done;
    logic              sat_flag;

    conv2d_event_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_x      (event_x),
        .event_y      (event_y),
        .event_spikes (event_spikes),
        .kern_rd_en   (kern_rd_en),
        .kern_addr    (kern_addr),
        .kern_data    (kern_data),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ready (mem_wr_ready),
        .busy         (busy),
        .event_done   (event_done),
        .sat_flag     (sat_flag)
    );

    int checks = 0;
    int errors = 0;

    // Memory / ROM model state
    logic [OUT*B-1:0] mem [NPIX];
    logic [OUT*W-1:0] rom [IN*K*K];
    int rd_delay = 0;
    int wr_delay = 0;
    int rd_count = 0;
    int wr_count = 0;
    int done_count = 0;
    int rd_hold_max = 0;
    int wr_hold_max = 0;
    int wr_addr_log[$];
    int kaddr_log[$];

    int rd_cnt = 0;
    int wr_cnt = 0;
    int wr_hold = 0;
    logic kern_prev = 1'b0;
    logic [AW-1:0]    rd_addr_held = '0;
    logic [AW-1:0]    wr_addr_held = '0;
    logic [OUT*B-1:0] wr_data_held = '0;

    function automatic logic [OUT*B-1:0] pack(input int c1, input int c0);
        logic [B-1:0] h;
        logic [B-1:0] l;
        h = B'(c1);
        l = B'(c0);
        return {h, l};
    endfunction

    // Responder: runs on the falling edge, so DUT outputs are settled and
    // responses are in place for the next rising edge.
    always @(negedge clk) begin
        // Kernel data is valid only for the cycle after the strobe; garbage otherwise.
        if (kern_rd_en) begin
            kern_data = rom[kern_addr];
            kaddr_log.push_back(int'(kern_addr));
        end else if (!kern_prev) begin
            kern_data = '1;
        end
        kern_prev = kern_rd_en;

        if (mem_rd_en) begin
            rd_cnt++;
            if (rd_cnt == 1) begin
                rd_addr_held = mem_rd_addr;
                rd_count++;
            end else begin
                checks++;
                if (mem_rd_addr !== rd_addr_held) begin
                    errors++;
                    $display("FAIL rd_addr_stable: got %0d required %0d", mem_rd_addr, rd_addr_held);
                end
            end
            if (rd_cnt > rd_hold_max) rd_hold_max = rd_cnt;
            if (rd_cnt > rd_delay) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = mem[mem_rd_addr];
            end else begin
                mem_rd_valid = 1'b0;
            end
        end else begin
            rd_cnt = 0;
            mem_rd_valid = 1'b0;
        end

        if (mem_wr_en) begin
            wr_hold++;
            if (wr_hold > wr_hold_max) wr_hold_max = wr_hold;
            wr_cnt++;
            if (wr_cnt == 1) begin
                wr_addr_held = mem_wr_addr;
                wr_data_held = mem_wr_data;
            end else begin
                checks++;
                if (mem_wr_addr !== wr_addr_held || mem_wr_data !== wr_data_held) begin
                    errors++;
                    $display("FAIL wr_stable: got %0d/%0h required %0d/%0h",
                             mem_wr_addr, mem_wr_data, wr_addr_held, wr_data_held);
                end
            end
            if (wr_cnt > wr_delay) begin
                mem_wr_ready = 1'b1;
                mem[mem_wr_addr] = mem_wr_data;
                wr_addr_log.push_back(int'(mem_wr_addr));
                wr_count++;
                wr_cnt = 0;
            end else begin
                mem_wr_ready = 1'b0;
            end
        end else begin
            wr_cnt = 0;
            wr_hold = 0;
            mem_wr_ready = 1'b0;
        end

        if (mem_rd_en && mem_wr_en) begin
            checks++;
            errors++;
            $display("FAIL rd_wr_overlap: got rd_en=1 wr_en=1 required not both");
        end
        if (event_done) done_count++;
    end

    task automatic clear_mem();
        for (int i = 0; i < NPIX; i++) mem[i] = '0;
    endtask

    task automatic set_rom(input logic [OUT*W-1:0] val);
        for (int i = 0; i < IN*K*K; i++) rom[i] = val;
    endtask

    task automatic start_event(input int x, input int y, input logic [IN-1:0] sp);
        @(negedge clk);
        event_x      = CB'(x);
        event_y      = CB'(y);
        event_spikes = sp;
        event_valid  = 1'b1;
        @(posedge clk);
        #1;
        event_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        checks++;
        if (n == budget) begin
            errors++;
            $display("FAIL %s_timeout: got busy after %0d cycles required idle", name, budget);
        end
    endtask

    task automatic test_reset();
        int strobes;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (event_ready !== 1'b1) begin errors++; $display("FAIL rst_event_ready: got %b required 1", event_ready); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (kern_rd_en !== 1'b0)  begin errors++; $display("FAIL rst_kern_rd_en: got %b required 0", kern_rd_en); end
        checks++; if (mem_rd_en !== 1'b0)   begin errors++; $display("FAIL rst_mem_rd_en: got %b required 0", mem_rd_en); end
        checks++; if (mem_wr_en !== 1'b0)   begin errors++; $display("FAIL rst_mem_wr_en: got %b required 0", mem_wr_en); end
        checks++; if (event_done !== 1'b0)  begin errors++; $display("FAIL rst_event_done: got %b required 0", event_done); end
        checks++; if (sat_flag !== 1'b0)    begin errors++; $display("FAIL rst_sat_flag: got %b required 0", sat_flag); end
        checks++; if (kern_addr !== '0 || mem_rd_addr !== '0 || mem_wr_addr !== '0 || mem_wr_data !== '0) begin
            errors++;
            $display("FAIL rst_buses: got %0h %0h %0h %0h required 0", kern_addr, mem_rd_addr, mem_wr_addr, mem_wr_data);
        end
        rst_n = 1'b1;
        strobes = 0;
        repeat (5) begin
            @(negedge clk);
            if (kern_rd_en || mem_rd_en || mem_wr_en || event_done || busy) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL post_rst_quiet: got %0d strobe cycles required 0", strobes);
        end
    endtask

    // Event (5,3), both channels, all weights +1: taps over x 4..6, y 2..4 twice.
    task automatic test_full_event(input string name);
        int rd0, wr0, dn0, wl0, kl0, idx, ex;
        logic [OUT*B-1:0] exp_v;
        clear_mem();
        set_rom(pack(1, 1));
        rd0 = rd_count; wr0 = wr_count; dn0 = done_count;
        wl0 = wr_addr_log.size(); kl0 = kaddr_log.size();
        start_event(5, 3, 2'b11);
        wait_idle(name, 2000);
        @(negedge clk); #1;
        checks++; if (wr_count - wr0 != 18) begin errors++; $display("FAIL %s_writes: got %0d required 18", name, wr_count - wr0); end
        checks++; if (rd_count - rd0 != 18) begin errors++; $display("FAIL %s_reads: got %0d required 18", name, rd_count - rd0); end
        checks++; if (done_count - dn0 != 1) begin errors++; $display("FAIL %s_done: got %0d required 1", name, done_count - dn0); end
        idx = 0;
        for (int ic = 0; ic < 2; ic++) begin
            for (int ky = 0; ky < 3; ky++) begin
                for (int kx = 0; kx < 3; kx++) begin
                    ex = (2 + ky) * 8 + (4 + kx);
                    checks++;
                    if (wl0 + idx >= wr_addr_log.size() || wr_addr_log[wl0 + idx] != ex) begin
                        errors++;
                        $display("FAIL %s_wr_order[%0d]: got %0d required %0d", name, idx,
                                 (wl0 + idx < wr_addr_log.size()) ? wr_addr_log[wl0 + idx] : -1, ex);
                    end
                    ex = ic * 9 + ky * 3 + kx;
                    checks++;
                    if (kl0 + idx >= kaddr_log.size() || kaddr_log[kl0 + idx] != ex) begin
                        errors++;
                        $display("FAIL %s_kaddr[%0d]: got %0d required %0d", name, idx,
                                 (kl0 + idx < kaddr_log.size()) ? kaddr_log[kl0 + idx] : -1, ex);
                    end
                    idx++;
                end
            end
        end
        for (int p = 0; p < NPIX; p++) begin
            exp_v = ((p % 8) >= 4 && (p % 8) <= 6 && (p / 8) >= 2 && (p / 8) <= 4) ? pack(2, 2) : '0;
            checks++;
            if (mem[p] !== exp_v) begin
                errors++;
                $display("FAIL %s_mem[%0d]: got %0h required %0h", name, p, mem[p], exp_v);
            end
        end
    endtask

    // Event (0,0), channel 0 only: four in-bounds taps, no wrapped addresses.
    task automatic test_corner();
        int wr0, wl0, kl0, dn0;
        int exp_a[4];
        int exp_k[4];
        logic [OUT*B-1:0] exp_v;
        exp_a = '{0, 1, 8, 9};
        exp_k = '{4, 5, 7, 8};
        clear_mem();
        set_rom(pack(1, 1));
        wr0 = wr_count; dn0 = done_count;
        wl0 = wr_addr_log.size(); kl0 = kaddr_log.size();
        start_event(0, 0, 2'b01);
        wait_idle("corner", 2000);
        @(negedge clk); #1;
        checks++; if (wr_count - wr0 != 4) begin errors++; $display("FAIL corner_writes: got %0d required 4", wr_count - wr0); end
        checks++; if (done_count - dn0 != 1) begin errors++; $display("FAIL corner_done: got %0d required 1", done_count - dn0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wl0 + i >= wr_addr_log.size() || wr_addr_log[wl0 + i] != exp_a[i]) begin
                errors++;
                $display("FAIL corner_addr[%0d]: got %0d required %0d", i,
                         (wl0 + i < wr_addr_log.size()) ? wr_addr_log[wl0 + i] : -1, exp_a[i]);
            end
            checks++;
            if (kl0 + i >= kaddr_log.size() || kaddr_log[kl0 + i] != exp_k[i]) begin
                errors++;
                $display("FAIL corner_kaddr[%0d]: got %0d required %0d", i,
                         (kl0 + i < kaddr_log.size()) ? kaddr_log[kl0 + i] : -1, exp_k[i]);
            end
        end
        for (int p = 0; p < NPIX; p++) begin
            exp_v = (p == 0 || p == 1 || p == 8 || p == 9) ? pack(1, 1) : '0;
            checks++;
            if (mem[p] !== exp_v) begin
                errors++;
                $display("FAIL corner_mem[%0d]: got %0h required %0h", p, mem[p], exp_v);
            end
        end
    endtask

    // Pixel 0 holds ch0=30, ch1=-30; weights ch0=+5, ch1=-5 -> 31 and -32.
    task automatic test_saturation();
        clear_mem();
        mem[0] = pack(-30, 30);
        set_rom(pack(-5, 5));
        start_event(0, 0, 2'b01);
        wait_idle("sat", 2000);
        @(negedge clk); #1;
        checks++; if (mem[0] !== pack(-32, 31)) begin errors++; $display("FAIL sat_clamp: got %0h required %0h", mem[0], pack(-32, 31)); end
        checks++; if (mem[9] !== pack(-5, 5))   begin errors++; $display("FAIL sat_plain: got %0h required %0h", mem[9], pack(-5, 5)); end
        checks++; if (sat_flag !== 1'b1)        begin errors++; $display("FAIL sat_flag_set: got %b required 1", sat_flag); end
    endtask

    // Zero spikes: done pulse in the second cycle after accept, no accesses;
    // also the accept must clear the sticky flag left by the previous event.
    task automatic test_zero_spikes();
        int rd0, wr0, dn0;
        rd0 = rd_count; wr0 = wr_count; dn0 = done_count;
        start_event(2, 2, 2'b00);
        checks++; if (sat_flag !== 1'b0)   begin errors++; $display("FAIL zero_sat_clear: got %b required 0", sat_flag); end
        checks++; if (event_done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL zero_cycle1: got done=%b busy=%b required 0/1", event_done, busy);
        end
        @(posedge clk); #1;
        checks++; if (event_done !== 1'b1) begin errors++; $display("FAIL zero_done_cycle2: got %b required 1", event_done); end
        @(posedge clk); #1;
        checks++; if (event_done !== 1'b0 || event_ready !== 1'b1) begin
            errors++; $display("FAIL zero_back_idle: got done=%b ready=%b required 0/1", event_done, event_ready);
        end
        @(negedge clk); #1;
        checks++; if (rd_count != rd0 || wr_count != wr0) begin
            errors++; $display("FAIL zero_no_access: got rd=%0d wr=%0d required 0/0", rd_count - rd0, wr_count - wr0);
        end
        checks++; if (done_count - dn0 != 1) begin errors++; $display("FAIL zero_done_count: got %0d required 1", done_count - dn0); end
    endtask

    task automatic test_stall();
        rd_delay = 3;
        wr_delay = 2;
        test_full_event("stall");
        rd_delay = 0;
        wr_delay = 0;
        checks++; if (rd_hold_max < 4) begin errors++; $display("FAIL stall_rd_held: got %0d required >=4", rd_hold_max); end
        checks++; if (wr_hold_max < 3) begin errors++; $display("FAIL stall_wr_held: got %0d required >=3", wr_hold_max); end
    endtask

    task automatic test_reset_mid_event();
        int wr0, dn0, n;
        clear_mem();
        set_rom(pack(1, 1));
        wr0 = wr_count; dn0 = done_count;
        start_event(5, 3, 2'b11);
        for (n = 0; n < 500; n++) begin
            @(negedge clk); #1;
            if (wr_count - wr0 >= 5) break;
        end
        checks++;
        if (n == 500) begin errors++; $display("FAIL midrst_reach5: got %0d writes required 5", wr_count - wr0); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || event_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_idle: got busy=%b ready=%b required 0/1", busy, event_ready);
        end
        checks++; if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 || kern_rd_en !== 1'b0) begin
            errors++; $display("FAIL midrst_strobes: got wr=%b rd=%b k=%b required 0", mem_wr_en, mem_rd_en, kern_rd_en);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        checks++; if (wr_count - wr0 != 5) begin errors++; $display("FAIL midrst_no_more_writes: got %0d required 5", wr_count - wr0); end
        checks++; if (done_count != dn0)   begin errors++; $display("FAIL midrst_no_done: got %0d required 0", done_count - dn0); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_stays_idle: got %b required 0", busy); end
    endtask

    initial begin
        clear_mem();
        set_rom(pack(1, 1));
        test_reset();
        test_full_event("full");
        test_corner();
        test_saturation();
        test_zero_spikes();
        test_stall();
        test_reset_mid_event();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
